// File: rtl/hollywood_pkg.sv
// Shared types and constants for the candidate sweep front end
// of the hollywood hash pipeline.
package hollywood_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DATA,
        S_DRAIN1,
        S_DRAIN2
    } state_e;

    localparam logic CH_DATA = 1'b0;
    localparam logic CH_MGMT = 1'b1;

    localparam int HIT_LATENCY = 2;

endpackage

// File: rtl/hollywood_candidate_gen.sv
// Sweeps base..limit into the hash core stream, one clear word per
// candidate, and records which candidates the core flagged.
module hollywood_candidate_gen
    import hollywood_pkg::*;
#(
    parameter int WORDS       = 2,
    parameter bit STOP_ON_HIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [16*WORDS-1:0]  base,
    input  logic [16*WORDS-1:0]  limit,
    output logic                 out_valid,
    output logic                 out_channel,
    output logic [15:0]          out_data,
    input  logic                 hit_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [16*WORDS-1:0]  found_value,
    output logic [15:0]          hit_count
);
    localparam int CW = 16 * WORDS;
    localparam logic [2:0] K_LAST = 3'(WORDS - 1);

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [CW-1:0]     cand_q, cand_d;
    logic [CW-1:0]     limit_q, limit_d;
    logic [HIT_LATENCY-1:0] pv_q;
    logic [CW-1:0]     pc_q [HIT_LATENCY];

    logic              out_valid_q, out_valid_d;
    logic              out_channel_q, out_channel_d;
    logic [15:0]       out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              found_q;
    logic [CW-1:0]     found_value_q;
    logic [15:0]       hit_count_q;

    logic              last_word, hit, abort, clr, push;
    logic [CW-1:0]     shifted;

    assign last_word = (state_q == S_DATA) && (k_q == K_LAST);
    assign hit       = pv_q[HIT_LATENCY-1] && hit_valid;
    assign abort     = (state_q != S_IDLE) && (stop || (STOP_ON_HIT && hit));
    assign push      = last_word && !abort;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cand_d  = cand_q;
        limit_d = limit_q;
        clr     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_CLEAR;
                    cand_d  = base;
                    limit_d = limit;
                    clr     = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = S_DATA;
                k_d     = 3'd0;
            end
            S_DATA: begin
                if (k_q == K_LAST) begin
                    cand_d = cand_q + {{(CW-1){1'b0}}, 1'b1};
                    // >= covers base > limit and avoids wrap at all-ones
                    state_d = (cand_q >= limit_q) ? S_DRAIN1 : S_CLEAR;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Output word is registered from the next state so it aligns with it
    always_comb begin
        shifted       = cand_d >> (16 * (WORDS - 1 - int'(k_d)));
        out_valid_d   = (state_d == S_CLEAR) || (state_d == S_DATA)
                     || (state_d == S_DRAIN1);
        out_channel_d = ((state_d == S_CLEAR) || (state_d == S_DRAIN1))
                      ? CH_MGMT : CH_DATA;
        out_data_d    = (state_d == S_DATA) ? shifted[15:0] : 16'd0;
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_q != S_IDLE) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            k_q           <= 3'd0;
            cand_q        <= '0;
            limit_q       <= '0;
            pv_q          <= '0;
            for (int i = 0; i < HIT_LATENCY; i++) pc_q[i] <= '0;
            out_valid_q   <= 1'b0;
            out_channel_q <= 1'b0;
            out_data_q    <= 16'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_value_q <= '0;
            hit_count_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cand_q        <= cand_d;
            limit_q       <= limit_d;
            pv_q[0]       <= push;
            pc_q[0]       <= cand_q;
            for (int i = 1; i < HIT_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1] && !abort;
                pc_q[i] <= pc_q[i-1];
            end
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            if (clr) begin
                found_q       <= 1'b0;
                found_value_q <= '0;
                hit_count_q   <= 16'd0;
            end else if (hit) begin
                found_q       <= 1'b1;
                found_value_q <= pc_q[HIT_LATENCY-1];
                if (hit_count_q != 16'hFFFF) begin
                    hit_count_q <= hit_count_q + 16'd1;
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_channel = out_channel_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign found_value = found_value_q;
    assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_hollywood_candidate_gen.sv
// Directed bench for hollywood_candidate_gen with a tiny core match
// model that raises hit_valid two cycles after the target word.
module tb_hollywood_candidate_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // u1: WORDS=1, stop on hit
    logic s1 = 0, p1 = 0;
    logic [15:0] b1 = 0, l1 = 0;
    logic ov1, ch1, bz1, dn1, fd1, hv1, m1;
    logic [15:0] od1, fv1, hc1;

    // u0: WORDS=1, full sweep
    logic s0 = 0, p0 = 0;
    logic [15:0] b0 = 0, l0 = 0;
    logic ov0, ch0, bz0, dn0, fd0, hv0, m0;
    logic [15:0] od0, fv0, hc0;

    // u2: WORDS=2, defaults, core never matches
    logic s2 = 0, p2 = 0;
    logic [31:0] b2 = 0, l2 = 0;
    logic ov2, ch2, bz2, dn2, fd2;
    logic hv2 = 1'b0;
    logic [15:0] od2, hc2;
    logic [31:0] fv2;

    hollywood_candidate_gen #(.WORDS(1), .STOP_ON_HIT(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .start(s1), .stop(p1),
        .base(b1), .limit(l1), .out_valid(ov1), .out_channel(ch1),
        .out_data(od1), .hit_valid(hv1), .busy(bz1), .done(dn1),
        .found(fd1), .found_value(fv1), .hit_count(hc1)
    );

    hollywood_candidate_gen #(.WORDS(1), .STOP_ON_HIT(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .start(s0), .stop(p0),
        .base(b0), .limit(l0), .out_valid(ov0), .out_channel(ch0),
        .out_data(od0), .hit_valid(hv0), .busy(bz0), .done(dn0),
        .found(fd0), .found_value(fv0), .hit_count(hc0)
    );

    hollywood_candidate_gen u2 (
        .clk(clk), .reset_n(reset_n), .start(s2), .stop(p2),
        .base(b2), .limit(l2), .out_valid(ov2), .out_channel(ch2),
        .out_data(od2), .hit_valid(hv2), .busy(bz2), .done(dn2),
        .found(fd2), .found_value(fv2), .hit_count(hc2)
    );

    // Core model: registered match, visible two cycles after the word
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m1 <= 0; hv1 <= 0; m0 <= 0; hv0 <= 0;
        end else begin
            m1  <= ov1 && !ch1 && (od1 == 16'h1234);
            hv1 <= m1;
            m0  <= ov0 && !ch0 && (od0 == 16'h1234);
            hv0 <= m0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int done_cyc, ndata, nmgmt, orphan, badseq, seen36;
    logic prev_mgmt;
    logic [15:0] last_d;
    logic [17:0] trace [1:6];

    initial begin
        #12 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", {ov2, ch2, bz2, dn2, fd2}, 5'b0);
        chk("rst_data", od2, 16'h0);
        chk("rst_fv_hc", {fv2, hc2}, 48'h0);

        // Single hit, stop on hit
        b1 = 16'h1230; l1 = 16'h1240; s1 = 1;
        @(negedge clk); s1 = 0;
        done_cyc = -1; seen36 = 0; last_d = 0;
        for (int c = 1; c < 100 && done_cyc < 0; c++) begin
            if (ov1 && !ch1) last_d = od1;
            if (ov1 && !ch1 && od1 == 16'h1236) seen36 = 1;
            if (dn1) done_cyc = c;
            if (!dn1) @(negedge clk);
        end
        chk("hit_done_cyc", done_cyc, 13);
        chk("hit_busy", bz1, 1'b0);
        chk("hit_found", fd1, 1'b1);
        chk("hit_value", fv1, 16'h1234);
        chk("hit_count", hc1, 16'd1);
        chk("hit_no_1236", seen36, 0);
        chk("hit_last_word", last_d, 16'h1235);
        @(negedge clk);
        chk("hit_done_pulse", dn1, 1'b0);

        // Full sweep, same range
        b0 = 16'h1230; l0 = 16'h1240; s0 = 1;
        @(negedge clk); s0 = 0;
        done_cyc = -1; ndata = 0; nmgmt = 0; orphan = 0; badseq = 0;
        prev_mgmt = 0;
        for (int c = 1; c < 100 && done_cyc < 0; c++) begin
            if (ov0 && ch0) nmgmt++;
            if (ov0 && !ch0) begin
                if (!prev_mgmt) orphan++;
                if (od0 != 16'h1230 + 16'(ndata)) badseq++;
                ndata++;
            end
            prev_mgmt = ov0 && ch0;
            if (dn0) done_cyc = c;
            if (!dn0) @(negedge clk);
        end
        chk("full_ndata", ndata, 17);
        chk("full_nmgmt", nmgmt, 18);
        chk("full_orphan", orphan, 0);
        chk("full_seq", badseq, 0);
        chk("full_done_cyc", done_cyc, 37);
        chk("full_count", hc0, 16'd1);
        chk("full_value", fv0, 16'h1234);

        // Degenerate range base > limit
        @(negedge clk);
        b0 = 16'd5; l0 = 16'd2; s0 = 1;
        @(negedge clk); s0 = 0;
        done_cyc = -1; ndata = 0;
        for (int c = 1; c <= 6; c++) begin
            trace[c] = {ov0, ch0, od0};
            if (ov0 && !ch0) ndata++;
            if (dn0 && done_cyc < 0) done_cyc = c;
            @(negedge clk);
        end
        chk("deg_c1", trace[1], {2'b11, 16'h0});
        chk("deg_c2", trace[2], {2'b10, 16'h5});
        chk("deg_c3", trace[3], {2'b11, 16'h0});
        chk("deg_c4", trace[4], {2'b00, 16'h0});
        chk("deg_ndata", ndata, 1);
        chk("deg_done_cyc", done_cyc, 5);
        chk("deg_found_clr", {fd0, hc0}, 17'h0);

        // WORDS=2 word order
        b2 = 32'hAABBCCDD; l2 = 32'hAABBCCDD; s2 = 1;
        @(negedge clk); s2 = 0;
        for (int c = 1; c <= 6; c++) begin
            trace[c] = {ov2, ch2, od2};
            if (c == 6) chk("w2_end", {dn2, bz2}, 2'b10);
            if (c == 5) chk("w2_busy5", {dn2, bz2}, 2'b01);
            @(negedge clk);
        end
        chk("w2_c1", trace[1], {2'b11, 16'h0});
        chk("w2_c2", trace[2], {2'b10, 16'hAABB});
        chk("w2_c3", trace[3], {2'b10, 16'hCCDD});
        chk("w2_c4", trace[4], {2'b11, 16'h0});
        chk("w2_c5", trace[5][17], 1'b0);

        // Stop on second data word
        b2 = 32'h0001_0000; l2 = 32'h0001_0005; s2 = 1;
        @(negedge clk); s2 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("stop_w1", {ov2, ch2, od2}, {2'b10, 16'h0000});
        p2 = 1;
        @(negedge clk); p2 = 0;
        chk("stop_out", {ov2, dn2, bz2, fd2}, 4'b0100);
        @(negedge clk);
        chk("stop_idle", {ov2, dn2, bz2}, 3'b000);

        // start with stop in idle
        s2 = 1; p2 = 1;
        @(negedge clk); s2 = 0; p2 = 0;
        chk("startstop", {ov2, bz2}, 2'b00);

        // Reset mid-sweep
        b2 = 32'h12345678; l2 = 32'h12345678; s2 = 1;
        @(negedge clk); s2 = 0;
        @(negedge clk);
        chk("pre_rst", od2, 16'h1234);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out", {ov2, ch2, bz2, dn2, od2}, 20'h0);
        chk("arst_u0", {fd0, fv0, hc0}, 33'h0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {ov2, bz2}, 2'b00);
        s2 = 1;
        @(negedge clk); s2 = 0;
        chk("rst_c1", {ov2, ch2, bz2, od2}, {3'b111, 16'h0});
        done_cyc = -1;
        for (int c = 1; c < 40 && done_cyc < 0; c++) begin
            if (dn2) done_cyc = c;
            if (!dn2) @(negedge clk);
        end
        chk("rst_done_cyc", done_cyc, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
